cr_osf_debug_sw_access: RTL and testbench

- Software/register-side controller for the output-FIFO debug path; the counterpart of the FIFO's hardware-side debug gating.
- Owns the FIFO debug mode register.
- Generates single-step read releases for a requested entry count.
- Services software peek-and-pop and inject transactions into the FIFO while hardware access is blocked.
- Sits between the register block and the output-FIFO debug gating logic.

---
 rtl/cr_osf_debug_sw_access_pkg.sv | 20 ++
 rtl/cr_osf_debug_sw_access.sv | 190 +++++++++++++++++++
 tb/tb_cr_osf_debug_sw_access.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_osf_debug_sw_access_pkg.sv
// Shared types for the output-FIFO debug software access controller.
// The mode encoding matches the register-block debug mode field.
package cr_osf_debug_sw_access_pkg;

    typedef enum logic [1:0] {
        OSF_DEBUG_NORMAL   = 2'd0,
        OSF_DEBUG_BLK_RDWR = 2'd1,
        OSF_DEBUG_BLK_RD   = 2'd2,
        OSF_DEBUG_SS       = 2'd3
    } osf_debug_mode_e;

    typedef enum logic [2:0] {
        OSF_DBG_IDLE   = 3'd0,
        OSF_DBG_SS_RUN = 3'd1,
        OSF_DBG_SW_RD  = 3'd2,
        OSF_DBG_SW_WR  = 3'd3,
        OSF_DBG_ACK    = 3'd4
    } osf_dbg_sw_state_e;

endpackage

// File: rtl/cr_osf_debug_sw_access.sv
// Purpose: debug-mode register, single-step release and SW peek/pop/inject for the output FIFO.
// Latency: accepted SW read/write acks 2 cycles after the request; single-step acks on the last release.
// Backpressure: none; commands outside IDLE are refused with an error ack. Optional: CR_OSF_DEBUG_SS_TIMEOUT_EN.
module cr_osf_debug_sw_access
    import cr_osf_debug_sw_access_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned SS_CNT_W = 16,
    parameter int unsigned TO_W     = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_mode_wr,
    input  logic [1:0]          cfg_debug_mode,
    input  logic                ss_cmd_valid,
    input  logic [SS_CNT_W-1:0] ss_cmd_cnt,
    input  logic                sw_rd_req,
    input  logic                sw_wr_req,
    input  logic [DATA_W-1:0]   sw_wdata,
    input  logic [DATA_W-1:0]   fifo_rdata,
    input  logic                fifo_empty,
    input  logic                fifo_full,
    input  logic                fifo_hw_rd,
    output logic [1:0]          fifo_debug_mode,
    output logic                single_step_rd,
    output logic                fifo_sw_rd,
    output logic                fifo_sw_wr,
    output logic [DATA_W-1:0]   fifo_sw_wdata,
    output logic [DATA_W-1:0]   sw_rd_data,
    output logic                sw_ack,
    output logic                sw_err,
    output logic                ss_busy,
    output logic [SS_CNT_W-1:0] ss_remaining,
    output logic                ss_timeout
);

    osf_dbg_sw_state_e state;
    osf_debug_mode_e   mode_q;
    logic [TO_W-1:0]   to_cnt;
    logic              to_expired;
    logic              rd_ok;
    logic              wr_ok;
    logic              ss_ok;

    assign fifo_debug_mode = mode_q;

    assign rd_ok = (mode_q == OSF_DEBUG_BLK_RDWR) && !fifo_empty;
    assign wr_ok = ((mode_q == OSF_DEBUG_BLK_RDWR) || (mode_q == OSF_DEBUG_BLK_RD)) && !fifo_full;
    assign ss_ok = (mode_q == OSF_DEBUG_SS) && (ss_cmd_cnt != '0);

    // The idle counter only gets an abort path when the timeout build is selected.
`ifdef CR_OSF_DEBUG_SS_TIMEOUT_EN
    assign to_expired = (to_cnt == {TO_W{1'b1}});
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= OSF_DBG_IDLE;
            mode_q         <= OSF_DEBUG_NORMAL;
            to_cnt         <= '0;
            single_step_rd <= 1'b0;
            fifo_sw_rd     <= 1'b0;
            fifo_sw_wr     <= 1'b0;
            fifo_sw_wdata  <= '0;
            sw_rd_data     <= '0;
            sw_ack         <= 1'b0;
            sw_err         <= 1'b0;
            ss_busy        <= 1'b0;
            ss_remaining   <= '0;
            ss_timeout     <= 1'b0;
        end else begin
            fifo_sw_rd <= 1'b0;
            fifo_sw_wr <= 1'b0;
            sw_ack     <= 1'b0;
            sw_err     <= 1'b0;

            if (cfg_mode_wr) begin
                mode_q     <= osf_debug_mode_e'(cfg_debug_mode);
                ss_timeout <= 1'b0;
            end

            // Any command seen while busy is refused; real completions below override this.
            if (state != OSF_DBG_IDLE && (ss_cmd_valid || sw_rd_req || sw_wr_req)) begin
                sw_ack <= 1'b1;
                sw_err <= 1'b1;
            end

            case (state)
                OSF_DBG_IDLE: begin
                    if (cfg_mode_wr) begin
                        if (ss_cmd_valid || sw_rd_req || sw_wr_req) begin
                            sw_ack <= 1'b1;
                            sw_err <= 1'b1;
                        end
                    end else if (ss_cmd_valid) begin
                        if (ss_ok) begin
                            ss_remaining   <= ss_cmd_cnt;
                            single_step_rd <= 1'b1;
                            ss_busy        <= 1'b1;
                            to_cnt         <= '0;
                            state          <= OSF_DBG_SS_RUN;
                            if (sw_rd_req || sw_wr_req) begin
                                sw_ack <= 1'b1;
                                sw_err <= 1'b1;
                            end
                        end else begin
                            sw_ack <= 1'b1;
                            sw_err <= 1'b1;
                            state  <= OSF_DBG_ACK;
                        end
                    end else if (sw_rd_req) begin
                        if (rd_ok) begin
                            sw_rd_data <= fifo_rdata;
                            fifo_sw_rd <= 1'b1;
                            state      <= OSF_DBG_SW_RD;
                            if (sw_wr_req) begin
                                sw_ack <= 1'b1;
                                sw_err <= 1'b1;
                            end
                        end else begin
                            sw_rd_data <= '0;
                            sw_ack     <= 1'b1;
                            sw_err     <= 1'b1;
                            state      <= OSF_DBG_ACK;
                        end
                    end else if (sw_wr_req) begin
                        if (wr_ok) begin
                            fifo_sw_wdata <= sw_wdata;
                            fifo_sw_wr    <= 1'b1;
                            state         <= OSF_DBG_SW_WR;
                        end else begin
                            sw_ack <= 1'b1;
                            sw_err <= 1'b1;
                            state  <= OSF_DBG_ACK;
                        end
                    end
                end

                OSF_DBG_SS_RUN: begin
                    if (cfg_mode_wr) begin
                        ss_remaining   <= '0;
                        single_step_rd <= 1'b0;
                        ss_busy        <= 1'b0;
                        to_cnt         <= '0;
                        state          <= OSF_DBG_IDLE;
                    end else if (fifo_hw_rd) begin
                        ss_remaining <= ss_remaining - 1'b1;
                        to_cnt       <= '0;
                        // Drop the release on the same edge the last entry is consumed.
                        if (ss_remaining == SS_CNT_W'(1)) begin
                            single_step_rd <= 1'b0;
                            ss_busy        <= 1'b0;
                            sw_ack         <= 1'b1;
                            sw_err         <= 1'b0;
                            state          <= OSF_DBG_ACK;
                        end
                    end else if (to_expired) begin
                        ss_remaining   <= '0;
                        single_step_rd <= 1'b0;
                        ss_busy        <= 1'b0;
                        to_cnt         <= '0;
                        ss_timeout     <= 1'b1;
                        sw_ack         <= 1'b1;
                        sw_err         <= 1'b1;
                        state          <= OSF_DBG_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                OSF_DBG_SW_RD, OSF_DBG_SW_WR: begin
                    sw_ack <= 1'b1;
                    sw_err <= 1'b0;
                    state  <= OSF_DBG_ACK;
                end

                OSF_DBG_ACK: begin
                    state <= OSF_DBG_IDLE;
                end

                default: begin
                    state <= OSF_DBG_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr_osf_debug_sw_access.sv
// Directed per-cycle vector table for cr_osf_debug_sw_access plus reset and timeout sequences.
module tb_cr_osf_debug_sw_access;

    localparam int DW = 64;
    localparam int CW = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [63:0] Z  = 64'h0;
    localparam logic [63:0] DB = 64'hDEAD_BEEF;
    localparam logic [63:0] CF = 64'h0000_0000_0000_CAFE;
    localparam logic [63:0] A5 = 64'h0000_0000_0000_A5A5;
    localparam logic [63:0] W1 = 64'h1234_5678_9ABC_DEF0;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_mode_wr;
    logic [1:0]    cfg_debug_mode;
    logic          ss_cmd_valid;
    logic [CW-1:0] ss_cmd_cnt;
    logic          sw_rd_req;
    logic          sw_wr_req;
    logic [DW-1:0] sw_wdata;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_hw_rd;
    logic [1:0]    fifo_debug_mode;
    logic          single_step_rd;
    logic          fifo_sw_rd;
    logic          fifo_sw_wr;
    logic [DW-1:0] fifo_sw_wdata;
    logic [DW-1:0] sw_rd_data;
    logic          sw_ack;
    logic          sw_err;
    logic          ss_busy;
    logic [CW-1:0] ss_remaining;
    logic          ss_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cr_osf_debug_sw_access #(
        .DATA_W   (DW),
        .SS_CNT_W (CW),
        .TO_W     (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_mode_wr     (cfg_mode_wr),
        .cfg_debug_mode  (cfg_debug_mode),
        .ss_cmd_valid    (ss_cmd_valid),
        .ss_cmd_cnt      (ss_cmd_cnt),
        .sw_rd_req       (sw_rd_req),
        .sw_wr_req       (sw_wr_req),
        .sw_wdata        (sw_wdata),
        .fifo_rdata      (fifo_rdata),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .fifo_hw_rd      (fifo_hw_rd),
        .fifo_debug_mode (fifo_debug_mode),
        .single_step_rd  (single_step_rd),
        .fifo_sw_rd      (fifo_sw_rd),
        .fifo_sw_wr      (fifo_sw_wr),
        .fifo_sw_wdata   (fifo_sw_wdata),
        .sw_rd_data      (sw_rd_data),
        .sw_ack          (sw_ack),
        .sw_err          (sw_err),
        .ss_busy         (ss_busy),
        .ss_remaining    (ss_remaining),
        .ss_timeout      (ss_timeout)
    );

    typedef struct {
        string         name;
        logic          cm;
        logic [1:0]    md;
        logic          ssv;
        logic [CW-1:0] cnt;
        logic          rd;
        logic          wr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rdat;
        logic          emp;
        logic          full;
        logic          hw;
        logic [1:0]    e_md;
        logic          e_ssrd;
        logic          e_busy;
        logic [CW-1:0] e_rem;
        logic          e_srd;
        logic          e_swr;
        logic          e_ack;
        logic          e_err;
        logic [DW-1:0] e_rdd;
        logic [DW-1:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_mode_wr    = 1'b0;
        cfg_debug_mode = 2'd0;
        ss_cmd_valid   = 1'b0;
        ss_cmd_cnt     = '0;
        sw_rd_req      = 1'b0;
        sw_wr_req      = 1'b0;
        sw_wdata       = '0;
        fifo_rdata     = '0;
        fifo_empty     = 1'b0;
        fifo_full      = 1'b0;
        fifo_hw_rd     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        //           name          cm md    ssv cnt    rd wr wd  rdat emp full hw   e_md  ssrd busy rem    srd swr ack err rdd wd
        vecs.push_back('{"idle",        L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd0,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"mode3",       H,2'd3,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_start4",   L,2'd0,H,16'd4,L,L,Z, Z, L,L,L, 2'd3,H,H,16'd4,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_rd1",      L,2'd0,L,16'd0,L,L,Z, Z, L,L,H, 2'd3,H,H,16'd3,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_gap1",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,H,H,16'd3,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_rd2",      L,2'd0,L,16'd0,L,L,Z, Z, L,L,H, 2'd3,H,H,16'd2,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_gap2",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,H,H,16'd2,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_rd3",      L,2'd0,L,16'd0,L,L,Z, Z, L,L,H, 2'd3,H,H,16'd1,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_gap3",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,H,H,16'd1,L,L,L,L,Z, Z});
        vecs.push_back('{"ss_rd4_ack",  L,2'd0,L,16'd0,L,L,Z, Z, L,L,H, 2'd3,L,L,16'd0,L,L,H,L,Z, Z});
        vecs.push_back('{"ss_done",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"mode1",       H,2'd1,L,16'd0,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"rd_pop",      L,2'd0,L,16'd0,H,L,Z, DB,L,L,L, 2'd1,L,L,16'd0,H,L,L,L,DB,Z});
        vecs.push_back('{"rd_ack",      L,2'd0,L,16'd0,L,L,Z, A5,L,L,L, 2'd1,L,L,16'd0,L,L,H,L,DB,Z});
        vecs.push_back('{"rd_idle",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,L,L,DB,Z});
        vecs.push_back('{"rd_empty",    L,2'd0,L,16'd0,H,L,Z, DB,H,L,L, 2'd1,L,L,16'd0,L,L,H,H,Z, Z});
        vecs.push_back('{"rd_empty_end",L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"mode0",       H,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd0,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"wr_normal",   L,2'd0,L,16'd0,L,H,A5,Z, L,L,L, 2'd0,L,L,16'd0,L,L,H,H,Z, Z});
        vecs.push_back('{"wr_norm_end", L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd0,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"mode2",       H,2'd2,L,16'd0,L,L,Z, Z, L,L,L, 2'd2,L,L,16'd0,L,L,L,L,Z, Z});
        vecs.push_back('{"wr_push",     L,2'd0,L,16'd0,L,H,W1,Z, L,L,L, 2'd2,L,L,16'd0,L,H,L,L,Z, W1});
        vecs.push_back('{"wr_ack",      L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd2,L,L,16'd0,L,L,H,L,Z, W1});
        vecs.push_back('{"wr_idle",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd2,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"wr_full",     L,2'd0,L,16'd0,L,H,A5,Z, L,H,L, 2'd2,L,L,16'd0,L,L,H,H,Z, W1});
        vecs.push_back('{"wr_full_end", L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd2,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"mode3b",      H,2'd3,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"ss_cnt0",     L,2'd0,H,16'd0,L,L,Z, Z, L,L,L, 2'd3,L,L,16'd0,L,L,H,H,Z, W1});
        vecs.push_back('{"ss_cnt0_end", L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"ss_start2",   L,2'd0,H,16'd2,L,L,Z, Z, L,L,L, 2'd3,H,H,16'd2,L,L,L,L,Z, W1});
        vecs.push_back('{"ss_abort",    H,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd0,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"abort_idle",  L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd0,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"mode3c",      H,2'd3,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"ss_start3",   L,2'd0,H,16'd3,L,L,Z, Z, L,L,L, 2'd3,H,H,16'd3,L,L,L,L,Z, W1});
        vecs.push_back('{"rd_in_ss",    L,2'd0,L,16'd0,H,L,Z, DB,L,L,L, 2'd3,H,H,16'd3,L,L,H,H,Z, W1});
        vecs.push_back('{"ss_hold",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,H,H,16'd3,L,L,L,L,Z, W1});
        vecs.push_back('{"ss3_rd1",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,H, 2'd3,H,H,16'd2,L,L,L,L,Z, W1});
        vecs.push_back('{"ss3_rd2",     L,2'd0,L,16'd0,L,L,Z, Z, L,L,H, 2'd3,H,H,16'd1,L,L,L,L,Z, W1});
        vecs.push_back('{"ss3_rd3_ack", L,2'd0,L,16'd0,L,L,Z, Z, L,L,H, 2'd3,L,L,16'd0,L,L,H,L,Z, W1});
        vecs.push_back('{"ss3_done",    L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd3,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"prio_cfg_rd", H,2'd1,L,16'd0,H,L,Z, DB,L,L,L, 2'd1,L,L,16'd0,L,L,H,H,Z, W1});
        vecs.push_back('{"prio_end",    L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,L,L,Z, W1});
        vecs.push_back('{"prio_rd_wr",  L,2'd0,L,16'd0,H,H,A5,CF,L,L,L, 2'd1,L,L,16'd0,H,L,H,H,CF,W1});
        vecs.push_back('{"prio_rd_ack", L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,H,L,CF,W1});
        vecs.push_back('{"prio_rd_end", L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,L,L,CF,W1});
        vecs.push_back('{"ss_bad_mode", L,2'd0,H,16'd5,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,H,H,CF,W1});
        vecs.push_back('{"ss_bad_end",  L,2'd0,L,16'd0,L,L,Z, Z, L,L,L, 2'd1,L,L,16'd0,L,L,L,L,CF,W1});

        // Reset state
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst.mode", 64'(fifo_debug_mode), 64'd0);
        chk("rst.ssrd", 64'(single_step_rd), 64'd0);
        chk("rst.sw_rd", 64'(fifo_sw_rd), 64'd0);
        chk("rst.sw_wr", 64'(fifo_sw_wr), 64'd0);
        chk("rst.ack", 64'(sw_ack), 64'd0);
        chk("rst.err", 64'(sw_err), 64'd0);
        chk("rst.busy", 64'(ss_busy), 64'd0);
        chk("rst.rem", 64'(ss_remaining), 64'd0);
        chk("rst.rdd", sw_rd_data, 64'd0);
        chk("rst.wd", fifo_sw_wdata, 64'd0);
        chk("rst.timeout", 64'(ss_timeout), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cfg_mode_wr    = vecs[i].cm;
            cfg_debug_mode = vecs[i].md;
            ss_cmd_valid   = vecs[i].ssv;
            ss_cmd_cnt     = vecs[i].cnt;
            sw_rd_req      = vecs[i].rd;
            sw_wr_req      = vecs[i].wr;
            sw_wdata       = vecs[i].wd;
            fifo_rdata     = vecs[i].rdat;
            fifo_empty     = vecs[i].emp;
            fifo_full      = vecs[i].full;
            fifo_hw_rd     = vecs[i].hw;
            tick();
            chk({vecs[i].name, ".mode"}, 64'(fifo_debug_mode), 64'(vecs[i].e_md));
            chk({vecs[i].name, ".ssrd"}, 64'(single_step_rd), 64'(vecs[i].e_ssrd));
            chk({vecs[i].name, ".busy"}, 64'(ss_busy), 64'(vecs[i].e_busy));
            chk({vecs[i].name, ".rem"}, 64'(ss_remaining), 64'(vecs[i].e_rem));
            chk({vecs[i].name, ".sw_rd"}, 64'(fifo_sw_rd), 64'(vecs[i].e_srd));
            chk({vecs[i].name, ".sw_wr"}, 64'(fifo_sw_wr), 64'(vecs[i].e_swr));
            chk({vecs[i].name, ".ack"}, 64'(sw_ack), 64'(vecs[i].e_ack));
            chk({vecs[i].name, ".err"}, 64'(sw_err), 64'(vecs[i].e_err));
            chk({vecs[i].name, ".rdd"}, sw_rd_data, vecs[i].e_rdd);
            chk({vecs[i].name, ".wd"}, fifo_sw_wdata, vecs[i].e_wd);
        end
        clear_inputs();

        // Reset during an in-flight software pop: pulse suppressed, no ack.
        sw_rd_req  = 1'b1;
        fifo_rdata = 64'h55;
        tick();
        sw_rd_req = 1'b0;
        chk("mid_rst.pop_before", 64'(fifo_sw_rd), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst.pop", 64'(fifo_sw_rd), 64'd0);
        chk("mid_rst.ack", 64'(sw_ack), 64'd0);
        chk("mid_rst.mode", 64'(fifo_debug_mode), 64'd0);
        chk("mid_rst.rdd", sw_rd_data, 64'd0);
        tick();
        chk("mid_rst.ack_after", 64'(sw_ack), 64'd0);

        // Single-step with no downstream consumption.
        cfg_mode_wr    = 1'b1;
        cfg_debug_mode = 2'd3;
        tick();
        cfg_mode_wr  = 1'b0;
        ss_cmd_valid = 1'b1;
        ss_cmd_cnt   = 16'd2;
        tick();
        ss_cmd_valid = 1'b0;
        chk("stall.busy_start", 64'(ss_busy), 64'd1);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (sw_ack) begin
                n = c + 1;
                break;
            end
        end
`ifdef CR_OSF_DEBUG_SS_TIMEOUT_EN
        chk("timeout.latency", 64'(n), 64'd16);
        chk("timeout.err", 64'(sw_err), 64'd1);
        chk("timeout.flag", 64'(ss_timeout), 64'd1);
        chk("timeout.rem", 64'(ss_remaining), 64'd0);
        chk("timeout.ssrd", 64'(single_step_rd), 64'd0);
        tick();
        tick();
        tick();
        chk("timeout.sticky", 64'(ss_timeout), 64'd1);
`else
        chk("stall.no_ack", 64'(n), 64'd0);
        chk("stall.busy", 64'(ss_busy), 64'd1);
        chk("stall.ssrd", 64'(single_step_rd), 64'd1);
        chk("stall.rem", 64'(ss_remaining), 64'd2);
        chk("stall.timeout", 64'(ss_timeout), 64'd0);
`endif
        cfg_mode_wr    = 1'b1;
        cfg_debug_mode = 2'd0;
        tick();
        cfg_mode_wr = 1'b0;
        chk("stall_end.timeout", 64'(ss_timeout), 64'd0);
        chk("stall_end.busy", 64'(ss_busy), 64'd0);
        chk("stall_end.ssrd", 64'(single_step_rd), 64'd0);
        chk("stall_end.mode", 64'(fifo_debug_mode), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
